// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC stall/redirect, keeps one imem request in flight,
// drops responses made stale by a redirect and buffers one instruction for decode.
module fetch_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_stall_pc,
    output logic              o_pc_update_control,
    output logic [ADDR_W-1:0] o_pc_update_val,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_trap_valid,
    input  logic [ADDR_W-1:0] i_trap_target,
    input  logic              i_br_valid,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_if_valid,
    output logic [31:0]       o_if_instr,
    output logic [ADDR_W-1:0] o_if_pc,
    input  logic              i_id_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic              kill;
    logic              buf_valid;
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc;

    logic              redir;
    logic [ADDR_W-1:0] target;
    logic              grant;
    logic              fresh;
    logic              fill;
    logic              take;

    // A redirect held during reset must not leak onto the PC controls.
    assign redir  = (i_trap_valid | i_br_valid) & i_rst_n;
    assign target = i_trap_valid ? i_trap_target : i_br_target;

    assign o_imem_req  = (state == REQ) & (~buf_valid | i_id_ready);
    assign o_imem_addr = req_addr;

    assign grant = o_imem_req & i_imem_gnt;
    assign fresh = grant & ~kill;

    assign o_stall_pc          = ~redir & ~fresh;
    assign o_pc_update_control = redir;
    assign o_pc_update_val     = redir ? target : '0;

    assign o_if_valid = buf_valid & ~redir;
    assign o_if_instr = buf_instr;
    assign o_if_pc    = buf_pc;

    assign fill = (state == WAIT) & i_imem_rvalid & ~kill & ~redir;
    assign take = o_if_valid & i_id_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            req_addr <= '0;
            kill     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    req_addr <= redir ? target : i_pc;
                end
                REQ: begin
                    if (grant) begin
                        state <= WAIT;
                        if (redir) kill <= 1'b1;
                    end else if (redir) begin
                        req_addr <= target;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        kill     <= 1'b0;
                        state    <= REQ;
                        req_addr <= redir ? target : i_pc;
                    end else if (redir) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Requests are only issued when the buffer will be free, so a fill never overwrites.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (redir) begin
            buf_valid <= 1'b0;
        end else if (fill) begin
            buf_valid <= 1'b1;
            buf_instr <= i_imem_rdata;
            buf_pc    <= req_addr;
        end else if (take) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC unit and imem models, directed stimulus,
// scoreboard of expected decode handshakes checked by a separate monitor.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        upd_ctrl;
    logic [31:0] upd_val;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt_en;
    logic        rvalid;
    logic [31:0] rdata;
    logic        trap_v;
    logic [31:0] trap_t;
    logic        br_v;
    logic [31:0] br_t;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    logic        rsp_en;
    logic        pending;
    logic [31:0] paddr;
    logic [31:0] pc_rst_val;

    int ntests;
    int nfail;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_in_q[$];

    fetch_ctrl #(.ADDR_W(32)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pc               (pc),
        .o_stall_pc         (stall),
        .o_pc_update_control(upd_ctrl),
        .o_pc_update_val    (upd_val),
        .o_imem_req         (imem_req),
        .o_imem_addr        (imem_addr),
        .i_imem_gnt         (gnt_en),
        .i_imem_rvalid      (rvalid),
        .i_imem_rdata       (rdata),
        .i_trap_valid       (trap_v),
        .i_trap_target      (trap_t),
        .i_br_valid         (br_v),
        .i_br_target        (br_t),
        .o_if_valid         (if_valid),
        .o_if_instr         (if_instr),
        .o_if_pc            (if_pc),
        .i_id_ready         (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // PC unit model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= pc_rst_val;
        else if (upd_ctrl) pc <= upd_val;
        else if (!stall) pc <= pc + 32'd4;
    end

    // Instruction memory: response one cycle after grant, gated by rsp_en
    always @(posedge clk) begin
        if (rvalid) pending <= 1'b0;
        if (imem_req && gnt_en) begin
            pending <= 1'b1;
            paddr   <= imem_addr;
        end
    end
    assign rvalid = pending & rsp_en;
    assign rdata  = mem(paddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chkb({nm, "_req"}, imem_req, 1'b0);
        chkb({nm, "_ifv"}, if_valid, 1'b0);
        chkb({nm, "_stall"}, stall, 1'b1);
        chkb({nm, "_updc"}, upd_ctrl, 1'b0);
        chk({nm, "_updv"}, upd_val, 32'h0);
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_pc_q.push_back(a);
        exp_in_q.push_back(mem(a));
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every decode handshake must match the next expected fetch
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            if (exp_pc_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_fetch: got pc %h expected none", if_pc);
            end else begin
                chk("fetch_pc", if_pc, exp_pc_q.pop_front());
                chk("fetch_instr", if_instr, exp_in_q.pop_front());
            end
        end
    end

    initial begin
        ntests = 0;
        nfail = 0;
        rst_n = 1'b0;
        pc_rst_val = 32'h0;
        pending = 1'b0;
        paddr = 32'h0;
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        id_ready = 1'b1;
        trap_v = 1'b0;
        trap_t = 32'h0;
        br_v = 1'b0;
        br_t = 32'h0;
        nc();
        nc();
        mid();
        chk_reset("rst0");
        nc();
        rst_n = 1'b1;
        mid();
        chkb("idle_req", imem_req, 1'b0);
        nc();

        // Sequential stream 0,4,8,C with a grant every other cycle
        for (int i = 0; i < 4; i++) expect_fetch(32'(i * 4));
        for (int k = 0; k < 7; k++) begin
            mid();
            chkb("seq_req", imem_req, (k % 2 == 0));
            chkb("seq_stall", stall, (k % 2 != 0));
            chkb("seq_updc", upd_ctrl, 1'b0);
            if (k % 2 == 0) chk("seq_addr", imem_addr, 32'(k * 2));
            nc();
        end
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        chkb("drain_stall", stall, 1'b1);
        chkb("drain_req", imem_req, 1'b1);
        nc();

        // Back-pressure from decode
        id_ready = 1'b0;
        gnt_en = 1'b1;
        expect_fetch(32'h10);
        mid();
        chk("bp_addr", imem_addr, 32'h10);
        chkb("bp_stall", stall, 1'b0);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        for (int k = 0; k < 3; k++) begin
            mid();
            chkb("bp_hold_req", imem_req, 1'b0);
            chkb("bp_hold_valid", if_valid, 1'b1);
            chk("bp_hold_pc", if_pc, 32'h10);
            chk("bp_hold_instr", if_instr, mem(32'h10));
            nc();
        end
        id_ready = 1'b1;
        gnt_en = 1'b1;
        expect_fetch(32'h14);
        mid();
        chkb("bp_resume_req", imem_req, 1'b1);
        chk("bp_resume_addr", imem_addr, 32'h14);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        nc();

        // Branch redirect while waiting for a response
        gnt_en = 1'b1;
        rsp_en = 1'b0;
        mid();
        chk("br_pre_addr", imem_addr, 32'h18);
        nc();
        gnt_en = 1'b0;
        br_v = 1'b1;
        br_t = 32'h200;
        mid();
        chkb("br_updc", upd_ctrl, 1'b1);
        chk("br_updv", upd_val, 32'h200);
        chkb("br_stall", stall, 1'b0);
        nc();
        br_v = 1'b0;
        rsp_en = 1'b1;
        mid();
        chkb("br_updc_off", upd_ctrl, 1'b0);
        chk("br_updv_off", upd_val, 32'h0);
        nc();
        gnt_en = 1'b1;
        expect_fetch(32'h200);
        mid();
        chkb("br_drop", if_valid, 1'b0);
        chkb("br_req", imem_req, 1'b1);
        chk("br_addr", imem_addr, 32'h200);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        nc();

        // Trap and branch together: trap wins
        trap_v = 1'b1;
        trap_t = 32'h100;
        br_v = 1'b1;
        br_t = 32'h200;
        mid();
        chkb("prio_updc", upd_ctrl, 1'b1);
        chk("prio_updv", upd_val, 32'h100);
        nc();
        trap_v = 1'b0;
        br_v = 1'b0;
        gnt_en = 1'b1;
        expect_fetch(32'h100);
        mid();
        chk("prio_addr", imem_addr, 32'h100);
        chkb("prio_req", imem_req, 1'b1);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        nc();

        // Redirect in the same cycle as a grant
        gnt_en = 1'b1;
        br_v = 1'b1;
        br_t = 32'h300;
        mid();
        chkb("gr_req", imem_req, 1'b1);
        chkb("gr_stall", stall, 1'b0);
        chkb("gr_updc", upd_ctrl, 1'b1);
        nc();
        br_v = 1'b0;
        gnt_en = 1'b0;
        mid();
        chkb("gr_wait_stall", stall, 1'b1);
        nc();
        gnt_en = 1'b1;
        expect_fetch(32'h300);
        mid();
        chkb("gr_drop", if_valid, 1'b0);
        chk("gr_addr", imem_addr, 32'h300);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        nc();

        // Reset while a response is outstanding
        gnt_en = 1'b1;
        rsp_en = 1'b0;
        mid();
        chkb("rst_pre_req", imem_req, 1'b1);
        nc();
        gnt_en = 1'b0;
        pc_rst_val = 32'h80;
        rst_n = 1'b0;
        mid();
        chk_reset("rst_mid");
        nc();
        rst_n = 1'b1;
        rsp_en = 1'b1;
        mid();
        chkb("rst_idle_ifv", if_valid, 1'b0);
        chkb("rst_idle_req", imem_req, 1'b0);
        nc();
        gnt_en = 1'b1;
        expect_fetch(32'h80);
        mid();
        chkb("rst_drop", if_valid, 1'b0);
        chkb("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 32'h80);
        nc();
        gnt_en = 1'b0;
        mid();
        nc();
        mid();
        nc();

        chk("sb_empty", 32'(exp_pc_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
